sram_responder: RTL and testbench

Synthesizable responder for the SLC-3 asynchronous-style SRAM strobe interface (CE, UB, LB, OE, WE active-low; 20-bit ADDR; 16-bit bidirectional Data). It takes the memory side of the bus the CPU drives. It holds an on-chip word array, answers reads after a fixed latency, and commits byte-laned writes when the write strobe is released. A side-band loader port preloads program images while the bus is idle, so the CPU can run on-board without external SRAM.

---
 rtl/sram_responder_if.sv | 24 ++
 rtl/sram_responder.sv | 186 ++++++++++++++++++
 tb/tb_sram_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// SLC-3 SRAM strobe bus as seen between the CPU and the memory responder.
// The 16-bit Data bus is bidirectional and is carried as a plain inout port
// on the responder; this interface groups the strobes and the address.
//   CE   chip enable, active-low
//   UB   upper byte lane (Data[15:8]) enable, active-low
//   LB   lower byte lane (Data[7:0]) enable, active-low
//   OE   output enable, active-low
//   WE   write enable, active-low
//   ADDR 20-bit word address
// Modports: master = CPU side (drives strobes), slave = responder side.
// ---------------------------------------------------------------------------
interface sram_responder_if;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;

  modport master (output CE, UB, LB, OE, WE, ADDR);
  modport slave  (input  CE, UB, LB, OE, WE, ADDR);
endinterface

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Memory-side responder for the SLC-3 SRAM strobe bus. Holds a 2^AW word
// array, returns read data READ_LAT cycles after a read request is first
// sampled, and commits byte-laned writes one cycle after the write strobe is
// released. A side-band loader fills the array while the bus is idle.
// Ports:
//   Clk         system clock, all state on rising edge
//   Reset       synchronous, active-low
//   bus         strobe/address group (slave modport)
//   Data        16-bit bidirectional bus, driven only while rd_valid is high
//   init_valid  loader word present
//   init_addr   loader word address
//   init_data   loader word (both bytes written)
//   init_ready  loader accepts when init_valid & init_ready
//   rd_valid    high exactly while the responder drives Data
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int AW       = 10,
  parameter int READ_LAT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  sram_responder_if.slave     bus,
  inout  wire  [15:0]         Data,
  input  logic                init_valid,
  input  logic [AW-1:0]       init_addr,
  input  logic [15:0]         init_data,
  output logic                init_ready,
  output logic                rd_valid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    DRIVE,
    WR_CAP,
    COMMIT
  } state_e;

  localparam logic [2:0] LAT  = 3'(READ_LAT);
  // With a one-cycle latency a (re)latched read goes straight to DRIVE.
  localparam bit         LAT1 = (READ_LAT == 1);

  logic [15:0]   mem [0:(1<<AW)-1];

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [2:0]    cnt_q,   cnt_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          ub_q,    ub_d;     // 1 = upper lane enabled for the pending write
  logic          lb_q,    lb_d;     // 1 = lower lane enabled for the pending write

  logic          req_wr;
  logic          req_rd;
  logic [AW-1:0] addr_in;
  logic          addr_same;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_wmask;

  logic          unused_addr_hi;

  // Upper address bits alias onto the array.
  assign unused_addr_hi = ^bus.ADDR[19:AW];
  assign addr_in        = bus.ADDR[AW-1:0];
  assign addr_same      = (addr_in == addr_q);

  // Write takes priority: WE low with OE low is a write and never drives.
  assign req_wr = ~bus.CE & ~bus.WE;
  assign req_rd = ~bus.CE & ~bus.OE & bus.WE;

  assign rd_valid   = (state_q == DRIVE);
  assign Data       = rd_valid ? mem[addr_q] : 16'hzzzz;

  // Loader only sees the array while the CPU is not selecting the chip.
  assign init_ready = Reset & bus.CE & (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    ub_d      = ub_q;
    lb_d      = lb_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = {ub_q, lb_q};

    case (state_q)
      IDLE: begin
        if (req_wr) begin
          addr_d  = addr_in;
          wdata_d = Data;
          ub_d    = ~bus.UB;
          lb_d    = ~bus.LB;
          state_d = WR_CAP;
        end else if (req_rd) begin
          addr_d  = addr_in;
          cnt_d   = 3'd1;
          state_d = LAT1 ? DRIVE : RD_WAIT;
        end
      end

      RD_WAIT, DRIVE: begin
        if (req_wr) begin
          addr_d  = addr_in;
          wdata_d = Data;
          ub_d    = ~bus.UB;
          lb_d    = ~bus.LB;
          state_d = WR_CAP;
        end else if (req_rd) begin
          if (!addr_same) begin
            // Address moved: restart the latency count on the new word.
            addr_d  = addr_in;
            cnt_d   = 3'd1;
            state_d = LAT1 ? DRIVE : RD_WAIT;
          end else if (state_q == RD_WAIT) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d == LAT) begin
              state_d = DRIVE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end

      WR_CAP: begin
        if (req_wr) begin
          // Last sample before the strobe releases is the one committed.
          addr_d  = addr_in;
          wdata_d = Data;
          ub_d    = ~bus.UB;
          lb_d    = ~bus.LB;
        end else begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        mem_we  = Reset;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (init_valid && init_ready) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr;
      mem_wdata = init_data;
      mem_wmask = 2'b11;
    end
  end

  // ---- state register boundary ----
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
    addr_q  <= addr_d;
    cnt_q   <= cnt_d;
    wdata_q <= wdata_d;
    ub_q    <= ub_d;
    lb_q    <= lb_d;
  end

  // ---- array write boundary ----
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (mem_wmask[1]) begin
        mem[mem_waddr][15:8] <= mem_wdata[15:8];
      end
      if (mem_wmask[0]) begin
        mem[mem_waddr][7:0] <= mem_wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Directed bench for sram_responder. A transaction-level model (word array,
// run length of an unchanged read request, pending-write flags) predicts
// rd_valid, init_ready and read data every cycle; literal expectations pin
// the model at the interesting cycles.
// ---------------------------------------------------------------------------
module tb_sram_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sram_responder_if bus();

  wire  [15:0]   Data;
  logic [15:0]   tb_dq;
  logic          tb_den;
  assign Data = tb_den ? tb_dq : 16'hzzzz;

  logic          init_valid;
  logic [AW-1:0] init_addr;
  logic [15:0]   init_data;
  logic          init_ready;
  logic          rd_valid;

  sram_responder #(.AW(AW), .READ_LAT(LAT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus),
    .Data       (Data),
    .init_valid (init_valid),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .init_ready (init_ready),
    .rd_valid   (rd_valid)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  logic [15:0]   mdl_mem [0:(1<<AW)-1];
  int            run;        // consecutive sampled cycles of the same read
  logic [AW-1:0] raddr;
  bit            wr_act;     // write strobe currently held
  bit            commit;     // write released, array updates at next edge
  logic [AW-1:0] waddr;
  logic [15:0]   wdat;
  bit            wub, wlb;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  function automatic bit model_ready();
    return Reset && bus.CE && (run == 0) && !wr_act && !commit;
  endfunction

  task automatic model_edge();
    bit rq_rd, rq_wr, ld;
    rq_wr = !bus.CE && !bus.WE;
    rq_rd = !bus.CE && !bus.OE && bus.WE;
    ld    = init_valid && model_ready();
    if (!Reset) begin
      run = 0; wr_act = 0; commit = 0;
    end else if (commit) begin
      if (wub) mdl_mem[waddr][15:8] = wdat[15:8];
      if (wlb) mdl_mem[waddr][7:0]  = wdat[7:0];
      commit = 0; run = 0;
    end else if (rq_wr) begin
      wr_act = 1; run = 0;
      waddr = bus.ADDR[AW-1:0]; wdat = tb_dq; wub = !bus.UB; wlb = !bus.LB;
    end else if (wr_act) begin
      wr_act = 0; commit = 1;
    end else if (rq_rd) begin
      if (run > 0 && bus.ADDR[AW-1:0] == raddr) run++;
      else begin raddr = bus.ADDR[AW-1:0]; run = 1; end
    end else begin
      run = 0;
    end
    if (ld) mdl_mem[init_addr] = init_data;
  endtask

  task automatic cmp_cycle();
    bit exp_v;
    exp_v = (run >= LAT);
    check("rd_valid", rd_valid, exp_v);
    check("init_ready", init_ready, model_ready());
    if (exp_v) check("Data", Data, mdl_mem[raddr]);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.CE = 1; bus.OE = 1; bus.WE = 1; bus.UB = 1; bus.LB = 1;
    bus.ADDR = '0; tb_den = 0; tb_dq = '0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    init_valid = 1; init_addr = a; init_data = d;
    step();
    init_valid = 0;
  endtask

  task automatic do_read(input logic [19:0] a, output logic [15:0] d, output logic v);
    for (int i = 0; i <= LAT; i++) begin
      bus.CE = 0; bus.OE = 0; bus.WE = 1; bus.ADDR = a;
      if (i == LAT) begin
        @(negedge Clk);
        d = Data; v = rd_valid;
      end
      step();
    end
    idle_bus();
    step();
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input logic oe, input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.CE = 0; bus.WE = 0; bus.OE = oe; bus.UB = ub; bus.LB = lb; bus.ADDR = a;
      tb_den = 1; tb_dq = d;
      @(negedge Clk);
      check("write no drive", rd_valid, 1'b0);
      step();
    end
    idle_bus();
    step();
    step();
  endtask

  initial begin
    logic [15:0] d;
    logic        v;
    Reset = 0; idle_bus();
    init_valid = 0; init_addr = '0; init_data = '0;
    run = 0; wr_act = 0; commit = 0; raddr = '0; waddr = '0; wdat = '0; wub = 0; wlb = 0;
    step(); step();
    fork
      forever begin @(posedge Clk); model_edge(); end
      forever begin @(negedge Clk); cmp_cycle(); end
    join_none
    @(negedge Clk);
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset init_ready", init_ready, 1'b0);
    step();
    Reset = 1;
    step();

    // Loader then read of address 5
    init_valid = 1; init_addr = 10'd5; init_data = 16'h1234;
    @(negedge Clk);
    check("loader ready idle", init_ready, 1'b1);
    step();
    init_valid = 0;
    bus.CE = 0; bus.OE = 0; bus.ADDR = 20'h00005;
    @(negedge Clk); check("rd c0 valid", rd_valid, 1'b0);
    step();
    @(negedge Clk); check("rd c1 valid", rd_valid, 1'b0);
    step();
    @(negedge Clk); check("rd c2 valid", rd_valid, 1'b1); check("rd c2 data", Data, 16'h1234);
    step();
    idle_bus();
    @(negedge Clk); check("rd release lag", rd_valid, 1'b1);
    step();
    @(negedge Clk); check("rd released", rd_valid, 1'b0);
    step();

    // Upper-lane write over 0x1111
    load(10'd7, 16'h1111);
    do_write(20'h00007, 16'hABCD, 1'b0, 1'b1, 1'b1, 2);
    do_read(20'h00007, d, v);
    check("ub write data", d, 16'hAB11);
    check("ub write valid", v, 1'b1);

    // OE and WE low together is a write
    do_write(20'h00009, 16'h5A5A, 1'b0, 1'b0, 1'b0, 2);
    do_read(20'h00009, d, v);
    check("oe+we write", d, 16'h5A5A);

    // Address change mid-read restarts latency
    load(10'd6, 16'h6666);
    bus.CE = 0; bus.OE = 0; bus.ADDR = 20'h00005;
    step();
    bus.ADDR = 20'h00006;
    @(negedge Clk); check("addr chg c1", rd_valid, 1'b0);
    step();
    @(negedge Clk); check("addr chg c2", rd_valid, 1'b0);
    step();
    @(negedge Clk); check("addr chg c3 valid", rd_valid, 1'b1); check("addr chg c3 data", Data, 16'h6666);
    step();
    idle_bus(); step(); step();

    // Loader held off while CE is low
    load(10'd13, 16'h1313);
    init_valid = 1; init_addr = 10'd13; init_data = 16'hBAD1;
    bus.CE = 0;
    @(negedge Clk); check("loader blocked", init_ready, 1'b0);
    step();
    @(negedge Clk); check("loader blocked 2", init_ready, 1'b0);
    step();
    init_addr = 10'd12; init_data = 16'hC0DE;
    bus.CE = 1;
    @(negedge Clk); check("loader resumes", init_ready, 1'b1);
    step();
    init_valid = 0;
    do_read(20'h0000C, d, v);
    check("loader word", d, 16'hC0DE);
    do_read(20'h0000D, d, v);
    check("blocked word kept", d, 16'h1313);

    // Aliasing above AW
    do_read(20'h00405, d, v);
    check("alias read", d, 16'h1234);
    do_write(20'h00408, 16'h0808, 1'b0, 1'b0, 1'b1, 1);
    do_read(20'h00008, d, v);
    check("alias write", d, 16'h0808);

    // Reset during DRIVE
    bus.CE = 0; bus.OE = 0; bus.ADDR = 20'h00005;
    step(); step();
    Reset = 0;
    @(negedge Clk); check("pre-reset drive", rd_valid, 1'b1);
    step();
    idle_bus();
    @(negedge Clk); check("reset drive stop", rd_valid, 1'b0);
    step();
    Reset = 1;
    step();

    // Reset during WR_CAP discards the write
    bus.CE = 0; bus.WE = 0; bus.UB = 0; bus.LB = 0; bus.ADDR = 20'h00007;
    tb_den = 1; tb_dq = 16'hFFFF;
    step();
    Reset = 0;
    step();
    idle_bus();
    step();
    Reset = 1;
    step(); step();
    do_read(20'h00007, d, v);
    check("reset write dropped", d, 16'hAB11);

    // Lower-lane only, then no lanes
    do_write(20'h00007, 16'h00CC, 1'b1, 1'b0, 1'b1, 1);
    do_read(20'h00007, d, v);
    check("lb write", d, 16'hABCC);
    do_write(20'h00007, 16'h9999, 1'b1, 1'b1, 1'b1, 2);
    do_read(20'h00007, d, v);
    check("no lane write", d, 16'hABCC);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
